ks_add_sched: RTL

Round-robin scheduler that shares one pipelined 16-bit Kogge-Stone adder among up to 8 requesters, such as butterfly real/imag adders and address/twiddle-index incrementers. It arbitrates requests with a valid/ready handshake and tags each accepted operation with its requester index. It carries that tag alongside the adder pipeline and returns the sum and carry-out to the originating requester. It sits between the FFT butterfly/control logic and the shared adder core, and a global hold freezes it when the FFT datapath stalls.

---
 rtl/ks_add_sched_pkg.sv | 42 ++++
 rtl/ks_add_sched_pipe16.sv | 66 ++++++
 rtl/ks_add_sched.sv | 82 ++++++++
 3 files changed

// File: rtl/ks_add_sched_pkg.sv
// ks_add_sched_pkg: shared widths, latency and Kogge-Stone pg/prefix-cell helpers
// for the shared-adder scheduler.
package ks_add_sched_pkg;

    localparam int KS_W   = 16;
    localparam int KS_LAT = 3;

    typedef struct packed {
        logic [KS_W-1:0] g;
        logic [KS_W-1:0] p;
    } gp_t;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Carry-in is folded into bit 0's generate so every group G[i] is the carry out of bit i.
    function automatic gp_t ks_pg(input logic [KS_W-1:0] a, input logic [KS_W-1:0] b, input logic c0);
        gp_t r;
        r.g    = a & b;
        r.p    = a ^ b;
        r.g[0] = r.g[0] | (r.p[0] & c0);
        return r;
    endfunction

    function automatic gp_t ks_cell(input gp_t x, input int d);
        gp_t r = x;
        for (int i = d; i < KS_W; i++) begin
            r.g[i] = x.g[i] | (x.p[i] & x.g[i-d]);
            r.p[i] = x.p[i] & x.p[i-d];
        end
        return r;
    endfunction

    function automatic logic [KS_W-1:0] ks_hi(input gp_t x);
        gp_t r = ks_cell(ks_cell(x, 4), 8);
        return r.g;
    endfunction

endpackage

// File: rtl/ks_add_sched_pipe16.sv
// ks_pipe16: 3-stage registered Kogge-Stone adder with a tag sideband
// (msb of the tag is the operation-valid bit) and a global enable.
module ks_pipe16
    import ks_add_sched_pkg::*;
#(
    parameter int TAG_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [KS_W-1:0]  i_a,
    input  logic [KS_W-1:0]  i_b,
    input  logic             i_c0,
    input  logic [TAG_W-1:0] i_tag,
    output logic [KS_W-1:0]  o_sum,
    output logic             o_cout,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy
);

    gp_t              pg0;
    gp_t              lv2;
    gp_t              s1_gp;
    logic [KS_W-1:0]  s1_p;
    logic             s1_c0;
    logic [TAG_W-1:0] s1_tag;
    logic [KS_W-1:0]  s2_g;
    logic [KS_W-1:0]  s2_p;
    logic             s2_c0;
    logic [TAG_W-1:0] s2_tag;

    assign pg0 = ks_pg(i_a, i_b, i_c0);
    assign lv2 = ks_cell(ks_cell(pg0, 1), 2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_gp  <= '0;
            s1_p   <= '0;
            s1_c0  <= 1'b0;
            s1_tag <= '0;
            s2_g   <= '0;
            s2_p   <= '0;
            s2_c0  <= 1'b0;
            s2_tag <= '0;
            o_sum  <= '0;
            o_cout <= 1'b0;
            o_tag  <= '0;
            o_busy <= 1'b0;
        end else if (i_en) begin
            s1_gp  <= lv2;
            s1_p   <= i_a ^ i_b;
            s1_c0  <= i_c0;
            s1_tag <= i_tag;
            s2_g   <= ks_hi(s1_gp);
            s2_p   <= s1_p;
            s2_c0  <= s1_c0;
            s2_tag <= s1_tag;
            o_sum  <= s2_p ^ {s2_g[KS_W-2:0], s2_c0};
            o_cout <= s2_g[KS_W-1];
            o_tag  <= s2_tag;
            // Next-state OR of the three stage valid bits, so busy comes straight from a flop.
            o_busy <= i_tag[TAG_W-1] | s1_tag[TAG_W-1] | s2_tag[TAG_W-1];
        end
    end

endmodule

// File: rtl/ks_add_sched.sv
// ks_add_sched: round-robin arbiter sharing one pipelined 16-bit Kogge-Stone adder
// among N_REQ requesters; responses are routed back by the tag carried through the pipe.
module ks_add_sched
    import ks_add_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_hold,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [KS_W*N_REQ-1:0]   i_req_a,
    input  logic [KS_W*N_REQ-1:0]   i_req_b,
    input  logic [N_REQ-1:0]        i_req_c0,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [N_REQ-1:0]        o_rsp_valid,
    output logic [KS_W-1:0]         o_rsp_sum,
    output logic                    o_rsp_cout,
    output logic [(clog2(N_REQ) < 1 ? 1 : clog2(N_REQ))-1:0] o_rsp_id,
    output logic                    o_busy
);

    localparam int ID_W = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  gid;
    logic [ID_W-1:0]  cand [N_REQ];
    logic             found;
    logic             hs;
    logic [N_REQ-1:0] gnt;
    logic [ID_W:0]    rsp_tag;

    // First valid requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        gid   = '0;
        gnt   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand[i] = ID_W'((int'(ptr) + i) % N_REQ);
            if (!found && i_req_valid[cand[i]]) begin
                found = 1'b1;
                gid   = cand[i];
            end
        end
        gnt[gid] = found;
    end

    assign o_req_ready = (i_rst_n && !i_hold) ? gnt : '0;
    assign hs          = found && !i_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            ptr <= '0;
        else if (hs)
            ptr <= (gid == ID_W'(N_REQ - 1)) ? '0 : gid + 1'b1;
    end

    ks_pipe16 #(
        .TAG_W (ID_W + 1)
    ) u_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (!i_hold),
        .i_a     (i_req_a[KS_W*gid +: KS_W]),
        .i_b     (i_req_b[KS_W*gid +: KS_W]),
        .i_c0    (i_req_c0[gid]),
        .i_tag   ({hs, gid}),
        .o_sum   (o_rsp_sum),
        .o_cout  (o_rsp_cout),
        .o_tag   (rsp_tag),
        .o_busy  (o_busy)
    );

    assign o_rsp_id = rsp_tag[ID_W-1:0];

    // A result parked in S3 during hold is strobed on the first cycle hold drops.
    always_comb begin
        o_rsp_valid           = '0;
        o_rsp_valid[o_rsp_id] = rsp_tag[ID_W] && !i_hold;
    end

endmodule
